// File: rtl/sync_fifo_fwft_pkg.sv
// Shared constants and helpers for the single-clock FIFO: address-width calculation,
// default flag thresholds and the per-cycle operation encoding.
package sync_fifo_fwft_pkg;

    localparam int AEMPTY_DEFAULT = 1;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Almost-full fires one word short of full unless overridden.
    function automatic int afull_default(input int depth);
        return depth - 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module sync_fifo_mem
    import sync_fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // Storage write: one word per accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with occupancy count, registered flags, overflow/underflow pulses
// and a choice of registered-read or first-word-fall-through output.
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter int DATA_WIDTH  = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_AFULL  = afull_default(FIFO_DEPTH),
    parameter int FIFO_AEMPTY = AEMPTY_DEFAULT,
    parameter int FWFT        = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          afull,
    output logic                          aempty,
    output logic                          empty,
    output logic [clog2(FIFO_DEPTH):0]    data_cnt,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int              AW       = clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_C  = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]     AFULL_C  = FIFO_AFULL[AW:0];
    localparam logic [AW:0]     AEMPTY_C = FIFO_AEMPTY[AW:0];
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1'b1);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    fifo_op_e              op_s;
    logic [DATA_WIDTH-1:0] mem_rd_s;

    // Acceptance uses the registered flags, so a write on full is dropped even if a read pops.
    always_comb begin
        wr_acc_s = wr_en & ~full_q;
        rd_acc_s = rd_en & ~empty_q;
        op_s     = fifo_op_e'({wr_acc_s, rd_acc_s});
    end

    // Next pointers, count and flags; flags derive from the next count so they move with it.
    always_comb begin
        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case (op_s)
            OP_WR:   cnt_d = cnt_q + CNT_ONE;
            OP_RD:   cnt_d = cnt_q - CNT_ONE;
            OP_RW:   cnt_d = cnt_q;
            OP_IDLE: cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase

        full_d      = (cnt_d == DEPTH_C);
        afull_d     = (cnt_d >= AFULL_C);
        aempty_d    = (cnt_d <= AEMPTY_C);
        empty_d     = (cnt_d == {(AW+1){1'b0}});
        overflow_d  = wr_en & full_q;
        underflow_d = rd_en & empty_q;
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            cnt_q       <= {(AW+1){1'b0}};
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc_s),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_s)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible straight from the array read port.
            assign rd_data = mem_rd_s;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

            // Capture the head word only when a read is accepted; hold otherwise.
            always_comb begin
                if (rd_acc_s) begin
                    rd_data_d = mem_rd_s;
                end else begin
                    rd_data_d = rd_data_q;
                end
            end

            // Registered read data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q <= {DATA_WIDTH{1'b0}};
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end

            assign rd_data = rd_data_q;
        end
    endgenerate

    assign full      = full_q;
    assign afull     = afull_q;
    assign aempty    = aempty_q;
    assign empty     = empty_q;
    assign data_cnt  = cnt_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Scoreboard bench: one registered-read and one FWFT instance share the same stimulus and are
// checked against a queue-based reference of FIFO behaviour.
module tb_sync_fifo_fwft;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en;
    logic [3:0] wr_data;

    logic [3:0] rd0, rd1, cnt0, cnt1;
    logic       full0, afull0, aempty0, empty0, ov0, un0;
    logic       full1, afull1, aempty1, empty1, ov1, un1;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [3:0] mdl_q[$];
    logic [3:0] exp_q0[$];
    logic [3:0] last0;
    logic       fire0;
    logic       exp_ov, exp_un;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.DATA_WIDTH(4), .FIFO_DEPTH(8), .FIFO_AFULL(7), .FIFO_AEMPTY(1), .FWFT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd0), .full(full0), .afull(afull0), .aempty(aempty0), .empty(empty0),
        .data_cnt(cnt0), .overflow(ov0), .underflow(un0));

    sync_fifo_fwft #(.DATA_WIDTH(4), .FIFO_DEPTH(8), .FIFO_AFULL(7), .FIFO_AEMPTY(1), .FWFT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd1), .full(full1), .afull(afull1), .aempty(aempty1), .empty(empty1),
        .data_cnt(cnt1), .overflow(ov1), .underflow(un1));

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        int c;
        c = mdl_q.size();
        chk("data_cnt0", int'(cnt0), c);   chk("data_cnt1", int'(cnt1), c);
        chk("empty0", int'(empty0), int'(c == 0));   chk("empty1", int'(empty1), int'(c == 0));
        chk("full0", int'(full0), int'(c == 8));     chk("full1", int'(full1), int'(c == 8));
        chk("afull0", int'(afull0), int'(c >= 7));   chk("afull1", int'(afull1), int'(c >= 7));
        chk("aempty0", int'(aempty0), int'(c <= 1)); chk("aempty1", int'(aempty1), int'(c <= 1));
        chk("overflow0", int'(ov0), int'(exp_ov));   chk("overflow1", int'(ov1), int'(exp_ov));
        chk("underflow0", int'(un0), int'(exp_un));  chk("underflow1", int'(un1), int'(exp_un));
    endtask

    // Drive one cycle (called at negedge+1), advance the reference, check flags at next negedge.
    task automatic cycle(input logic w, input logic [3:0] d, input logic r);
        int         c;
        logic [3:0] word;
        c       = mdl_q.size();
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        exp_ov  = w && (c == 8);
        exp_un  = r && (c == 0);
        if (r && c != 0) begin
            word = mdl_q.pop_front();
            exp_q0.push_back(word);
        end
        if (w && c != 8) mdl_q.push_back(d);
        @(negedge clk);
        check_flags();
        #1;
    endtask

    // Monitor: registered-read data is popped from the scoreboard when a read was accepted,
    // otherwise it must hold; FWFT data must equal the reference head whenever non-empty.
    initial begin
        logic [3:0] e;
        last0 = 4'd0;
        fire0 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last0 = 4'd0;
                fire0 = 1'b0;
            end
            if (fire0) begin
                if (exp_q0.size() == 0) begin
                    chk("sb_empty_on_read0", 1, 0);
                end else begin
                    e = exp_q0.pop_front();
                    chk("rd_data0", int'(rd0), int'(e));
                    last0 = e;
                end
            end else begin
                chk("rd_hold0", int'(rd0), int'(last0));
            end
            if (!empty1) begin
                if (mdl_q.size() == 0) chk("head1_present", 0, 1);
                else chk("rd_head1", int'(rd1), int'(mdl_q[0]));
            end
            #2;
            fire0 = rd_en && !empty0 && rst_n;
        end
    end

    initial begin
        int wp, rp;
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 4'd0;
        exp_ov  = 1'b0;
        exp_un  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        cycle(1'b0, 4'd0, 1'b0);
        for (int i = 13; i <= 20; i++) cycle(1'b1, 4'(i), 1'b0);
        cycle(1'b1, 4'hA, 1'b0);
        cycle(1'b1, 4'hB, 1'b0);
        repeat (8) cycle(1'b0, 4'd0, 1'b1);
        cycle(1'b0, 4'd0, 1'b1);
        cycle(1'b0, 4'd0, 1'b0);

        for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i), 1'b0);
        repeat (10) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b1);
        repeat (5) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0);
        cycle(1'b1, 4'h9, 1'b1);
        cycle(1'b1, 4'h6, 1'b1);
        repeat (3) cycle(1'b0, 4'd0, 1'b1);

        for (int k = 0; k < 400; k++) begin
            case ((k / 50) % 4)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                2:       begin wp = 50; rp = 50; end
                default: begin wp = 95; rp = 10; end
            endcase
            cycle(1'($urandom_range(0, 99) < wp), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 99) < rp));
        end
        repeat (9) cycle(1'b0, 4'd0, 1'b1);
        cycle(1'b0, 4'd0, 1'b0);
        chk("scoreboard_drained", exp_q0.size(), 0);

        for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 7), 1'b0);
        cycle(1'b0, 4'd0, 1'b1);
        cycle(1'b0, 4'd0, 1'b0);
        rst_n  = 1'b0;
        exp_ov = 1'b0;
        exp_un = 1'b0;
        mdl_q.delete();
        exp_q0.delete();
        @(negedge clk);
        check_flags();
        #1 rst_n = 1'b1;
        cycle(1'b1, 4'hC, 1'b0);
        cycle(1'b1, 4'h3, 1'b1);
        repeat (3) cycle(1'b0, 4'd0, 1'b1);
        cycle(1'b0, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
